// File: rtl/mii_pkg.sv
// Shared types and constants for the MII receive path.
package mii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DONE,
    ST_DROP
  } rx_state_t;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_nib.sv
// Combinational reflected CRC-32 step over one 4-bit nibble, LSB first.
module crc32_nib
  import mii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nib,
  output logic [31:0] crc_out
);

  // Four bit-serial shifts of the reflected LFSR
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {28'h0, nib};
    for (int unsigned i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/mii_rx_mac.sv
// MII nibble receiver: strips preamble/SFD, packs bytes into 16-bit RAM
// words, checks CRC-32 and reports each completed frame.
module mii_rx_mac
  import mii_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MAX_BYTES = 1518,
  parameter int MIN_BYTES = 64
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [3:0]        rxd,
  input  logic              rxdv,
  input  logic              rxer,
  input  logic              rx_ready,
  input  logic [ADDR_W-1:0] rx_base_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              pack_valid,
  output logic [ADDR_W-1:0] pack_addr,
  output logic [10:0]       pack_size,
  output logic              pack_crc_ok,
  output logic              pack_err,
  output logic              rx_busy,
  output logic [15:0]       drop_cnt
);

  // One spare bit so the count can exceed MAX_BYTES and still compare correctly.
  localparam int CNT_W = $clog2(MAX_BYTES + 1) + 1;

  rx_state_t         state;
  logic [31:0]       crc;
  logic [31:0]       crc_next;
  logic              phase;
  logic [3:0]        lo_nib;
  logic [7:0]        byte_lo;
  logic [CNT_W-1:0]  byte_cnt;
  logic [ADDR_W-1:0] base;
  logic              f_over;
  logic              f_rxer;

  crc32_nib u_crc (
    .crc_in  (crc),
    .nib     (rxd),
    .crc_out (crc_next)
  );

  assign rx_busy = (state != ST_IDLE);

  // Receive FSM with registered RAM write port and frame report
  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= ST_IDLE;
      crc         <= CRC_INIT;
      phase       <= 1'b0;
      lo_nib      <= '0;
      byte_lo     <= '0;
      byte_cnt    <= '0;
      base        <= '0;
      f_over      <= 1'b0;
      f_rxer      <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      pack_valid  <= 1'b0;
      pack_addr   <= '0;
      pack_size   <= '0;
      pack_crc_ok <= 1'b0;
      pack_err    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      wr_en      <= 1'b0;
      pack_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rxdv) state <= (rxd == PREAMBLE_NIB) ? ST_PREAMBLE : ST_DROP;
        end
        ST_PREAMBLE: begin
          if (!rxdv) begin
            state <= ST_IDLE;
          end else if (rxd == PREAMBLE_NIB) begin
            state <= ST_PREAMBLE;
          end else if (rxd == SFD_NIB) begin
            if (rx_ready) begin
              base     <= rx_base_addr;
              byte_cnt <= '0;
              phase    <= 1'b0;
              crc      <= CRC_INIT;
              f_over   <= 1'b0;
              f_rxer   <= 1'b0;
              state    <= ST_DATA;
            end else begin
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
              state <= ST_DROP;
            end
          end else begin
            state <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (rxer) f_rxer <= 1'b1;
          if (rxdv) begin
            crc   <= crc_next;
            phase <= ~phase;
            if (!phase) begin
              lo_nib <= rxd;
            end else begin
              if (byte_cnt >= CNT_W'(MAX_BYTES)) begin
                f_over <= 1'b1;
              end else if (!byte_cnt[0]) begin
                byte_lo <= {rxd, lo_nib};
              end else begin
                wr_en   <= 1'b1;
                wr_addr <= base + ADDR_W'(byte_cnt >> 1);
                wr_data <= {rxd, lo_nib, byte_lo};
              end
              if (byte_cnt != '1) byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end else begin
            // Report is issued on the DATA->DONE edge so it is visible during DONE.
            state       <= ST_DONE;
            pack_valid  <= 1'b1;
            pack_addr   <= base;
            pack_size   <= (byte_cnt < CNT_W'(4)) ? '0 : 11'(byte_cnt - CNT_W'(4));
            pack_crc_ok <= (crc == CRC_RESIDUE);
            pack_err    <= (byte_cnt < CNT_W'(MIN_BYTES)) | f_over | f_rxer | rxer | phase;
            if (byte_cnt[0] && (byte_cnt <= CNT_W'(MAX_BYTES))) begin
              wr_en   <= 1'b1;
              wr_addr <= base + ADDR_W'(byte_cnt >> 1);
              wr_data <= {8'h00, byte_lo};
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_DROP: begin
          if (!rxdv) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_rx_mac.sv
// Directed bench for mii_rx_mac.
module tb_mii_rx_mac;

  logic        clk = 1'b0;
  logic        arst;
  logic [3:0]  rxd;
  logic        rxdv;
  logic        rxer;
  logic        rx_ready;
  logic [10:0] rx_base_addr;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        pack_valid;
  logic [10:0] pack_addr;
  logic [10:0] pack_size;
  logic        pack_crc_ok;
  logic        pack_err;
  logic        rx_busy;
  logic [15:0] drop_cnt;

  mii_rx_mac #(.ADDR_W(11), .MAX_BYTES(1518), .MIN_BYTES(64)) dut (
    .clk          (clk),
    .arst         (arst),
    .rxd          (rxd),
    .rxdv         (rxdv),
    .rxer         (rxer),
    .rx_ready     (rx_ready),
    .rx_base_addr (rx_base_addr),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pack_valid   (pack_valid),
    .pack_addr    (pack_addr),
    .pack_size    (pack_size),
    .pack_crc_ok  (pack_crc_ok),
    .pack_err     (pack_err),
    .rx_busy      (rx_busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  frame_buf [0:2047];
  logic [10:0] wl_addr   [0:4095];
  logic [15:0] wl_data   [0:4095];
  int wr_total = 0;
  int pv_total = 0;
  int wr0, pv0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Record every RAM write and frame report away from the active edge
  always @(negedge clk) begin
    if (wr_en && wr_total < 4096) begin
      wl_addr[wr_total] = wr_addr;
      wl_data[wr_total] = wr_data;
      wr_total++;
    end
    if (pack_valid) pv_total++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame_buf[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build(input int npay, input bit flip);
    logic [31:0] fcs;
    for (int i = 0; i < npay; i++) frame_buf[i] = i[7:0];
    fcs = ~crc_of(npay);
    for (int k = 0; k < 4; k++) frame_buf[npay + k] = fcs[8*k +: 8];
    if (flip) frame_buf[npay][0] = ~frame_buf[npay][0];
  endtask

  task automatic nib(input logic dv, input logic [3:0] d, input logic er);
    rxdv = dv; rxd = d; rxer = er;
    @(posedge clk); #1;
  endtask

  task automatic preamble(input int n, input logic [3:0] last);
    for (int i = 0; i < n; i++) nib(1'b1, 4'h5, 1'b0);
    nib(1'b1, last, 1'b0);
  endtask

  task automatic send_bytes(input int n, input int er_at);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = frame_buf[i];
      nib(1'b1, b[3:0], (i == er_at));
      nib(1'b1, b[7:4], 1'b0);
    end
  endtask

  // Full frame: preamble + SFD, npay payload bytes + FCS, optional trailing nibble
  task automatic send_frame(input int npay, input logic [10:0] base, input bit flip,
                            input int er_at, input bit extra_nib, input string tag);
    build(npay, flip);
    rx_base_addr = base;
    wr0 = wr_total;
    pv0 = pv_total;
    preamble(15, 4'hD);
    send_bytes(npay + 4, er_at);
    if (extra_nib) nib(1'b1, 4'h3, 1'b0);
    nib(1'b0, 4'h0, 1'b0);
    chk({tag, "_pv_latency"}, pack_valid, 1'b1);
    repeat (3) nib(1'b0, 4'h0, 1'b0);
    chk({tag, "_pv_count"}, pv_total - pv0, 1);
  endtask

  initial begin
    arst = 1'b1; rxdv = 1'b0; rxd = 4'h0; rxer = 1'b0;
    rx_ready = 1'b1; rx_base_addr = 11'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_pack_valid", pack_valid, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    arst = 1'b0;
    nib(1'b0, 4'h0, 1'b0);

    // Good 60-byte payload frame
    send_frame(60, 11'h100, 1'b0, -1, 1'b0, "good");
    chk("good_writes", wr_total - wr0, 32);
    chk("good_first_addr", wl_addr[wr0], 11'h100);
    chk("good_first_data", wl_data[wr0], 16'h0100);
    chk("good_second_data", wl_data[wr0 + 1], 16'h0302);
    chk("good_last_addr", wl_addr[wr0 + 31], 11'h11F);
    chk("good_pack_addr", pack_addr, 11'h100);
    chk("good_size", pack_size, 60);
    chk("good_crc_ok", pack_crc_ok, 1);
    chk("good_err", pack_err, 0);
    chk("good_idle", rx_busy, 0);

    // Same frame, FCS bit flipped
    send_frame(60, 11'h200, 1'b1, -1, 1'b0, "badfcs");
    chk("badfcs_writes", wr_total - wr0, 32);
    chk("badfcs_crc_ok", pack_crc_ok, 0);
    chk("badfcs_err", pack_err, 0);
    chk("badfcs_pack_addr", pack_addr, 11'h200);

    // 20-byte runt
    send_frame(16, 11'h300, 1'b0, -1, 1'b0, "runt");
    chk("runt_writes", wr_total - wr0, 10);
    chk("runt_size", pack_size, 16);
    chk("runt_crc_ok", pack_crc_ok, 1);
    chk("runt_err", pack_err, 1);

    // 65-byte frame placed across the address wrap
    send_frame(61, 11'h7F0, 1'b0, -1, 1'b0, "odd");
    chk("odd_writes", wr_total - wr0, 33);
    chk("odd_last_addr", wl_addr[wr0 + 32], 11'h010);
    chk("odd_last_data", wl_data[wr0 + 32], {8'h00, frame_buf[64]});
    chk("odd_size", pack_size, 61);
    chk("odd_crc_ok", pack_crc_ok, 1);
    chk("odd_err", pack_err, 0);

    // rx_ready low at SFD
    build(60, 1'b0);
    rx_ready = 1'b0;
    wr0 = wr_total; pv0 = pv_total;
    preamble(15, 4'hD);
    chk("notready_busy", rx_busy, 1);
    send_bytes(64, -1);
    nib(1'b0, 4'h0, 1'b0);
    repeat (3) nib(1'b0, 4'h0, 1'b0);
    rx_ready = 1'b1;
    chk("notready_writes", wr_total - wr0, 0);
    chk("notready_pv", pv_total - pv0, 0);
    chk("notready_drop_cnt", drop_cnt, 1);

    // Bad preamble 5,5,7
    wr0 = wr_total; pv0 = pv_total;
    preamble(2, 4'h7);
    send_bytes(10, -1);
    nib(1'b0, 4'h0, 1'b0);
    repeat (3) nib(1'b0, 4'h0, 1'b0);
    chk("badpre_writes", wr_total - wr0, 0);
    chk("badpre_pv", pv_total - pv0, 0);
    chk("badpre_drop_cnt", drop_cnt, 1);

    // rxdv falls after a low nibble
    send_frame(60, 11'h400, 1'b0, -1, 1'b1, "align");
    chk("align_size", pack_size, 60);
    chk("align_err", pack_err, 1);

    // rxer pulsed mid-frame
    send_frame(60, 11'h500, 1'b0, 30, 1'b0, "rxer");
    chk("rxer_writes", wr_total - wr0, 32);
    chk("rxer_crc_ok", pack_crc_ok, 1);
    chk("rxer_err", pack_err, 1);

    // Reset in the middle of DATA
    build(60, 1'b0);
    rx_base_addr = 11'h600;
    wr0 = wr_total; pv0 = pv_total;
    preamble(15, 4'hD);
    send_bytes(20, -1);
    arst = 1'b1;
    nib(1'b1, 4'h4, 1'b0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_pack_valid", pack_valid, 0);
    chk("arst_busy", rx_busy, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    chk("arst_pack_addr", pack_addr, 0);
    chk("arst_pack_size", pack_size, 0);
    chk("arst_wr_data", wr_data, 0);
    arst = 1'b0;
    repeat (4) nib(1'b0, 4'h0, 1'b0);
    chk("arst_pv", pv_total - pv0, 0);
    chk("arst_writes", wr_total - wr0, 10);

    send_frame(60, 11'h080, 1'b0, -1, 1'b0, "after");
    chk("after_writes", wr_total - wr0, 32);
    chk("after_first_addr", wl_addr[wr0], 11'h080);
    chk("after_crc_ok", pack_crc_ok, 1);
    chk("after_err", pack_err, 0);
    chk("after_size", pack_size, 60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mii_rx_mac.md
Name: mii_rx_mac

Overview:
- MII nibble receiver, the receive-side counterpart of the packet transmitter.
- Strips preamble/SFD, assembles bytes low-nibble-first and packs them two per 16-bit word into the packet RAM write port.
- Runs CRC-32 over the frame including FCS and reports each completed frame with base, size and status.
- Sits between the PHY RX pins (already in the clk domain) and the shared packet RAM / packet-descriptor logic.

Parameters:
- ADDR_W, 11, packet RAM word-address width.
- MAX_BYTES, 1518, largest accepted frame in bytes, FCS included.
- MIN_BYTES, 64, smallest accepted frame in bytes, FCS included.

Ports:
- clk  in  1  RX clock; all logic on rising edge.
- arst  in  1  reset, synchronous, active-high.
- rxd  in  4  MII receive nibble.
- rxdv  in  1  MII receive data valid.
- rxer  in  1  MII receive error.
- rx_ready  in  1  downstream can accept a frame at rx_base_addr.
- rx_base_addr  in  ADDR_W  word address for the next frame; latched at SFD.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM word address.
- wr_data  out  16  byte n in [7:0], byte n+1 in [15:8].
- pack_valid  out  1  one-cycle frame-complete pulse.
- pack_addr  out  ADDR_W  latched base address of the frame.
- pack_size  out  11  byte count excluding FCS.
- pack_crc_ok  out  1  CRC residue matched.
- pack_err  out  1  runt, oversize, rxer or odd-nibble frame.
- rx_busy  out  1  high outside IDLE.
- drop_cnt  out  16  frames dropped because rx_ready was low; saturating.

Behaviour:
- Reset (arst high at an edge): state IDLE.
  - All outputs 0.
  - drop_cnt cleared.
  - CRC register set to 0xFFFFFFFF.
  - A frame in progress is abandoned: no write, no pack_valid.
- States: IDLE, PREAMBLE, DATA, DONE, DROP.
- IDLE:
  - rxdv=1 and rxd=5 -> PREAMBLE.
  - rxdv=1 and any other rxd -> DROP.
- PREAMBLE:
  - rxd=5 -> stay.
  - rxd=D with rx_ready=1 -> latch rx_base_addr, clear counters and CRC, go DATA.
  - rxd=D with rx_ready=0 -> increment drop_cnt, go DROP.
  - any other rxd -> DROP.
  - rxdv=0 -> IDLE.
  - No minimum preamble length.
- DATA:
  - Nibble phase toggles each cycle, low nibble first.
  - Each nibble advances a reflected nibble-wide CRC-32 (poly 0xEDB88320).
  - On each high nibble the byte completes and byte_cnt increments.
  - Even-indexed bytes are held in [7:0].
  - Odd-indexed bytes complete the word: the next cycle asserts wr_en with wr_addr = base + byte_cnt/2.
  - Bytes past MAX_BYTES are not written; they set the oversize flag.
  - rxer=1 while in DATA sets the error flag; reception continues.
  - rxdv=0 -> DONE. If the nibble phase is odd at that point, set the alignment error flag.
  - If byte_cnt is odd at end of frame, the last byte is written with [15:8]=0 in the DONE cycle.
- DONE (one cycle):
  - pack_valid=1 with pack_addr, pack_size = byte_cnt-4 (0 if byte_cnt<4).
  - pack_crc_ok = (CRC register == 0xDEBB20E3).
  - pack_err = runt (byte_cnt<MIN_BYTES) | oversize | rxer | alignment.
  - Next state: IDLE. pack_* values hold until the next pack_valid.
- DROP: no writes; wait for rxdv=0, then IDLE.
- rx_busy = (state != IDLE).
- Latency: pack_valid occurs on the edge after the first cycle rxdv is sampled low.
- A frame whose last word straddles the address wrap wraps modulo 2^ADDR_W; avoiding overlap is the allocator's responsibility.

Decomposition:
- Shared package mii_pkg:
  - state enum.
  - PREAMBLE_NIB=4'h5, SFD_NIB=4'hD.
  - CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3.
- One sub-module, crc32_nib: combinational next-CRC from {crc, nibble}. The register stays in mii_rx_mac.

Test Plan:
- 15×5, D, 60-byte payload 0x00..0x3B plus correct FCS, rx_ready=1, base=0x100 -> 32 writes at 0x100..0x11F; first wr_data=0x0100; pack_size=60, pack_crc_ok=1, pack_err=0.
- Same frame with one FCS bit flipped -> pack_crc_ok=0, pack_err=0, all writes still performed.
- 20-byte frame with valid FCS -> pack_size=16, pack_crc_ok=1, pack_err=1 (runt). 65-byte frame -> last write carries [15:8]=0.
- rx_ready=0 at SFD -> no wr_en, no pack_valid, drop_cnt 0->1. Preamble 5,5,7 -> DROP, no pack_valid, drop_cnt unchanged.
- rxdv falls after a low nibble; separately, rxer pulsed mid-frame -> pack_valid with pack_err=1 in both cases.
- arst asserted mid-DATA -> next edge all outputs 0, no pack_valid. Following frame received normally, with pack_crc_ok=1.
